// File: rtl/disp_scan4_pkg.sv
// disp_pkg: shared constants and the seven-segment decode table for the
// display blocks.
//   SEG_BLANK  - all segments (and dp) off on an active-low display
//   AN_OFF     - all anodes disabled on an active-low anode bus
//   seg_decode - nibble -> active-low {g,f,e,d,c,b,a}
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  // Lowercase b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/disp_scan4_if.sv
// disp_scan4_if: bundle between the counter chain / board and the scan driver.
//   hexs    - 16-bit value, [3:0] is the rightmost digit
//   points  - per-digit decimal point request, 1 = lit
//   les     - per-digit blank request, 1 = dark
//   lz_en   - 1 = suppress leading zeros on digits 3..1
//   an      - active-low anode enables
//   seg     - active-low segments {dp,g,f,e,d,c,b,a}
//   frame   - one-cycle pulse after a new input snapshot is taken
//   dbg_idx - digit index currently being scanned (scan state)
// There is no handshake: inputs are level signals sampled once per frame,
// outputs are free-running registered levels plus the frame pulse.
interface disp_scan4_if;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        lz_en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame;
  logic [1:0]  dbg_idx;

  modport master (
    output hexs, points, les, lz_en,
    input  an, seg, frame, dbg_idx
  );

  modport slave (
    input  hexs, points, les, lz_en,
    output an, seg, frame, dbg_idx
  );
endinterface

// File: rtl/disp_scan4_hex7seg.sv
// hex7seg: combinational nibble -> active-low seven-segment decoder.
//   nib - hex digit value
//   seg - active-low {g,f,e,d,c,b,a}
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = seg_decode(nib);

endmodule

// File: rtl/disp_scan4.sv
// disp_scan4: four-digit time-multiplexed common-anode display driver.
//   clk - system clock
//   rst - synchronous, active-high reset
//   bus - disp_scan4_if.slave: hex value, points, blanks, lz_en in;
//         an, seg, frame, dbg_idx out
// A divider lights each digit for SCAN_DIV cycles. All inputs are copied
// into shadow registers once per frame (on the tick that wraps idx 3->0)
// so a counter changing mid-scan never shows a mix of old and new digits.
module disp_scan4
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 131072
)(
  input  logic          clk,
  input  logic          rst,
  disp_scan4_if.slave   bus
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          tick;
  logic          capture;

  logic [15:0]   sh_hexs;
  logic [3:0]    sh_points;
  logic [3:0]    sh_les;
  logic          sh_lz;

  logic [3:0]    nib;
  logic          dp;
  logic          zsup;
  logic          dark;
  logic [6:0]    dec;

  logic [3:0]    an_q;
  logic [7:0]    seg_q;
  logic          frame_q;

  assign tick    = (div == DW'(SCAN_DIV - 1));
  assign capture = tick && (idx == 2'd3);

  // Digit selection from the shadow copy only, never from live inputs.
  assign nib = sh_hexs[{idx, 2'b00} +: 4];
  assign dp  = sh_points[idx];

  // A digit is a leading zero when it and every digit to its left are 0.
  always_comb begin
    zsup = 1'b0;
    case (idx)
      2'd1:    zsup = sh_lz && (sh_hexs[15:4]  == 12'h000);
      2'd2:    zsup = sh_lz && (sh_hexs[15:8]  == 8'h00);
      2'd3:    zsup = sh_lz && (sh_hexs[15:12] == 4'h0);
      default: zsup = 1'b0;
    endcase
  end

  assign dark = sh_les[idx] || zsup;

  hex7seg u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      idx       <= 2'd0;
      sh_hexs   <= 16'h0000;
      sh_points <= 4'h0;
      sh_les    <= 4'h0;
      sh_lz     <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
      frame_q   <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (capture) begin
        sh_hexs   <= bus.hexs;
        sh_points <= bus.points;
        sh_les    <= bus.les;
        sh_lz     <= bus.lz_en;
      end
      frame_q <= capture;
      // Outputs reflect the idx of this cycle, so they trail idx by one.
      an_q  <= ~(4'b0001 << idx);
      seg_q <= dark ? SEG_BLANK : {~dp, dec};
    end
  end

  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.frame   = frame_q;
  assign bus.dbg_idx = idx;

endmodule

// File: tb/tb_disp_scan4.sv
module tb_disp_scan4;

  logic clk;
  logic rst;

  disp_scan4_if bus ();

  disp_scan4 #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  string step_name = "init";

  // scoreboard: {an[3:0], seg[7:0], frame}
  logic [12:0] exp_q[$];

  task automatic push_exp(input logic [3:0] an_v, input logic [7:0] seg_v,
                          input logic fr);
    exp_q.push_back({an_v, seg_v, fr});
  endtask

  // One digit is lit for 4 cycles; the frame pulse, when expected, falls
  // on the last of those cycles (cycle after the capture edge).
  task automatic push_digit(input logic [3:0] an_v, input logic [7:0] seg_v,
                            input logic fr_last);
    for (int i = 0; i < 3; i++) push_exp(an_v, seg_v, 1'b0);
    push_exp(an_v, seg_v, fr_last);
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push_digit(4'hE, s0, 1'b0);
    push_digit(4'hD, s1, 1'b0);
    push_digit(4'hB, s2, 1'b0);
    push_digit(4'h7, s3, 1'b1);
  endtask

  task automatic run_cycles(input int n);
    logic [12:0] exp_v;
    logic [12:0] obs_v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs_v = {bus.an, bus.seg, bus.frame};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL %s: no expected entry queued, observed an=%h seg=%h frame=%b",
               step_name, obs_v[12:9], obs_v[8:1], obs_v[0]);
      end else begin
        exp_v = exp_q.pop_front();
        assert (obs_v === exp_v) else begin
          failures++;
          $error("FAIL %s: observed an=%h seg=%h frame=%b expected an=%h seg=%h frame=%b",
                 step_name, obs_v[12:9], obs_v[8:1], obs_v[0],
                 exp_v[12:9], exp_v[8:1], exp_v[0]);
        end
      end
    end
  endtask

  task automatic check_idx(input logic [1:0] exp_idx);
    checks++;
    assert (bus.dbg_idx === exp_idx) else begin
      failures++;
      $error("FAIL %s idx: observed %0d expected %0d", step_name, bus.dbg_idx, exp_idx);
    end
  endtask

  task automatic drive(input logic [15:0] h, input logic [3:0] p,
                       input logic [3:0] l, input logic lz);
    bus.hexs   = h;
    bus.points = p;
    bus.les    = l;
    bus.lz_en  = lz;
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h0000, 4'h0, 4'h0, 1'b0);

    // reset held for 3 cycles: all dark
    step_name = "reset_hold";
    for (int i = 0; i < 3; i++) push_exp(4'hF, 8'hFF, 1'b0);
    run_cycles(3);
    check_idx(2'd0);

    // release; first frame shows the zero shadow, captures 12AF at its end
    step_name = "reset_release";
    rst = 1'b0;
    drive(16'h12AF, 4'h0, 4'h0, 1'b0);
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    run_cycles(16);

    // scan order of 12AF; inputs change while idx = 1 must not tear
    step_name = "scan_order";
    push_frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
    run_cycles(4);
    check_idx(2'd1);
    drive(16'h3456, 4'b0100, 4'b1000, 1'b0);
    step_name = "tearing";
    run_cycles(12);

    // new snapshot: dp on digit 2, digit 3 blanked
    step_name = "points_blank";
    push_frame(8'h82, 8'h92, 8'h19, 8'hFF);
    drive(16'h0050, 4'h0, 4'h0, 1'b1);
    run_cycles(16);

    step_name = "lz_0050";
    push_frame(8'hC0, 8'h92, 8'hFF, 8'hFF);
    drive(16'h0000, 4'h0, 4'h0, 1'b1);
    run_cycles(16);

    step_name = "lz_zero";
    push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
    drive(16'h12AF, 4'h0, 4'h0, 1'b0);
    run_cycles(16);

    // mid-scan reset while digit 2 is selected
    step_name = "pre_midscan";
    push_digit(4'hE, 8'h8E, 1'b0);
    push_digit(4'hD, 8'h88, 1'b0);
    run_cycles(8);
    check_idx(2'd2);
    step_name = "midscan_reset";
    rst = 1'b1;
    push_exp(4'hF, 8'hFF, 1'b0);
    push_exp(4'hF, 8'hFF, 1'b0);
    run_cycles(1);
    check_idx(2'd0);
    run_cycles(1);
    rst = 1'b0;

    step_name = "after_reset";
    push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    run_cycles(16);
    step_name = "recapture";
    push_digit(4'hE, 8'h8E, 1'b0);
    run_cycles(4);

    step_name = "queue_drained";
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL %s: observed %0d entries left expected 0", step_name, exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan4.md
# disp_scan4

Four-digit time-multiplexed seven-segment display driver. Sits directly downstream of the cascaded 4-bit reversible counters: it takes their four nibble outputs as one 16-bit hex value and drives the board's common-anode display. A clock divider selects one digit at a time. Input values are captured once per frame so a counter changing mid-scan never shows torn digits.

## Interface
- SCAN_DIV, default 131072: clk cycles each digit is lit; legal range 2..2^20.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- hexs  in  16  digit values; [3:0] is digit 0 (rightmost), [15:12] is digit 3
- points  in  4  decimal point request per digit, 1 = lit
- les  in  4  per-digit blank request, 1 = digit dark
- lz_en  in  1  1 = suppress leading zeros on digits 3..1
- an  out  4  anode enables, active-low, one-hot-zero
- seg  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}
- frame  out  1  one-cycle pulse when a new input snapshot is taken

## Operation
- **Divider.** div counts 0..SCAN_DIV-1 and wraps. tick = (div == SCAN_DIV-1).
- **Digit index.** On tick, idx (2 bits) advances 0→1→2→3→0.
- **Snapshot capture.** The shadow registers (sh_hexs, sh_points, sh_les, sh_lz) load from the inputs on the tick where idx goes 3→0. frame pulses high in the cycle after that capture. Inputs are ignored at all other times.
- **Digit selection per cycle.** From the current idx and the shadow registers, compute:
  - nib = sh_hexs[4*idx+:4]
  - dp = sh_points[idx]
  - dark = sh_les[idx] OR zero-suppressed
- **Zero suppression.** Digit k (k ≥ 1) is zero-suppressed when sh_lz = 1 and sh_hexs nibbles k..3 are all 0. Digit 0 is never suppressed.
- **Outputs.**
  - an: the next cycle shows ~(4'b0001 << idx).
  - seg: the next cycle shows {~dp, decode(nib)}. When dark, seg = 8'hFF; an still selects the digit.
- **Decode, active-low {g..a}:**
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
  - The full seg value for "0" with dp off is C0.
- **Reset (synchronous, takes priority over everything):**
  - div = 0, idx = 0
  - all shadow registers = 0
  - an = 4'b1111, seg = 8'hFF, frame = 0
- **Reset mid-scan.** The next edge returns to idx 0 with displays dark. Capture waits for the next 3→0 tick.

## Timing
- All outputs are registered.
- an/seg lag idx by exactly 1 cycle.
- First cycle after rst deasserts: an = 4'b1110, seg = 8'hC0 (shadow is zero).
- Each digit is lit for SCAN_DIV cycles. A frame is 4·SCAN_DIV cycles.
- Input-to-display latency:
  - best case: 2 cycles after the capture edge;
  - worst case: one full frame plus 2 cycles.
- frame asserts exactly once per frame, 1 cycle wide, the cycle after the capture edge.
- SCAN_DIV = 2 is legal and gives tick on every other cycle.

## Structure
- **Package disp_pkg:**
  - SEG_BLANK = 8'hFF
  - AN_OFF = 4'hF
  - the 16-entry active-low segment table, as a constant function or array
- **Sub-module hex7seg:** combinational nibble → 7-bit active-low segment decoder, reusable by other display blocks.
- **Top level:** divider, idx register, shadow registers, zero-suppress logic and output registers. Target size about 150–200 lines.

## Test plan
Use SCAN_DIV = 4 in simulation.
- **Reset release.** Hold rst 3 cycles, then release → an=F/seg=FF during reset; an=E, seg=C0 on the first post-reset cycle; an=D after 4 cycles.
- **Scan order.** hexs = 16'h12AF; wait one frame for capture → digits 0..3 show seg 8E, 88, A4, F9 in order, each for 4 cycles; frame pulses every 16 cycles.
- **Tearing check.** Change hexs while idx = 1 → the display keeps the old value until the next capture; the new value appears 2 cycles after the frame capture edge.
- **Blank and decimal points.**
  - points = 4'b0100 → digit 2 seg bit7 = 0.
  - les = 4'b1000 → digit 3 seg = FF while an = 7.
- **Leading-zero suppression.** lz_en = 1, hexs = 16'h0050 → digits 3 and 2 read FF; digit 1 reads 92; digit 0 reads C0. With hexs = 0, only digit 0 shows C0.
- **Mid-scan reset.** Assert rst while idx = 2 → the next cycle an=F; after release, the scan restarts at digit 0 and the shadow is zero.
